adc_event_capture: RTL
======================

// Module: adc_event_capture
// PURPOSE
//  Downstream of the ADC front-end that emits a 16-bit magnitude stream (tvalid/tdata, no tready).
//  Detects threshold-crossing events and measures each one: start timestamp, duration in valid samples, and peak value.
//  Queues one 64-bit record per event in a small FIFO and drains it over AXI-Stream with backpressure toward the DMA/PS side.
// PARAMETERS
//  DATA_WIDTH  16  input sample width (fixed 16 at this stage)
//  TS_WIDTH    32  timestamp counter width
//  DUR_WIDTH   16  event duration counter width
//  FIFO_DEPTH  8   record FIFO depth, power of 2, >=2
// PORTS
//  aclk            in   1          system clock
//  aresetn         in   1          reset, synchronous, active-low
//  s_axis_tvalid   in   1          sample valid (no tready; always accepted)
//  s_axis_tdata    in   16         unsigned sample magnitude
//  cfg_enable      in   1          1 = detect/timestamp, 0 = idle and clear
//  cfg_threshold   in   16         event starts when sample > cfg_threshold
//  cfg_hysteresis  in   16         release margin; used only with ADC_EVT_HYST_EN
//  cfg_min_len     in   DUR_WIDTH  minimum duration to emit a record
//  m_axis_tvalid   out  1          record valid
//  m_axis_tready   in   1          record accepted
//  m_axis_tdata    out  64         {ts[31:0], dur[15:0], peak[15:0]}
//  sts_busy        out  1          FSM in ACTIVE
//  sts_fifo_level  out  clog2(D)+1 records held
//  sts_drop_cnt    out  16         records dropped on FIFO full, saturating
// BEHAVIOUR
//  Reset (aresetn=0 at posedge):
//   - FSM=IDLE; ts counter, FIFO, and all outputs = 0.
//  Timestamp:
//   - ts increments by 1 every cycle while cfg_enable=1, wrapping modulo 2^TS_WIDTH.
//   - ts is held at 0 while cfg_enable=0.
//  FSM IDLE -> ACTIVE:
//   - Trigger: tvalid & enable & tdata > cfg_threshold.
//   - Latch ts_start=ts (value in the same cycle), dur=1, peak=tdata.
//  FSM ACTIVE, each cycle with tvalid=1:
//   - If tdata > off_lvl: dur++ (saturates at all-ones); peak=tdata if tdata > peak (strict; tie keeps old).
//   - Else event ends: push record if dur >= cfg_min_len (min_len 0 and 1 are equivalent), then go to IDLE.
//   - The ending sample is not counted in dur or peak.
//   - The ending sample cannot start a new event in the same cycle.
//  tvalid=0 cycles: no state change, no dur increment.
//  cfg_enable 1->0: FSM to IDLE next cycle; the in-progress event is discarded (no record, no drop count).
//   - FIFO contents are kept and keep draining.
//  FIFO write when full:
//   - Record dropped; sts_drop_cnt++ (saturates at 0xFFFF).
//   - Exception: if a pop (tvalid&tready) happens in the same cycle, the write succeeds and level is unchanged.
//  Output:
//   - Registered first-word-fall-through.
//   - m_axis_tvalid rises the cycle after the record write into an empty FIFO (latency 1 from the ending sample edge).
//   - tdata is stable while tvalid=1 & tready=0; tvalid is never dropped before the handshake.
//   - Records are emitted in event order.
//  Record field widths:
//   - ts truncated/zero-extended to 32 bits.
//   - dur is zero-extended to 16 bits when DUR_WIDTH < 16; DUR_WIDTH > 16 is not supported in the 64-bit record.
// CONFIGURATION
//  ADC_EVT_HYST_EN defined:
//   - off_lvl = cfg_threshold - cfg_hysteresis, saturating at 0.
//  ADC_EVT_HYST_EN undefined:
//   - off_lvl = cfg_threshold; cfg_hysteresis is ignored (port remains).
// STRUCTURE
//  Package adc_evt_pkg:
//   - state enum {IDLE, ACTIVE}
//   - REC_WIDTH=64
//   - field offsets TS_LSB=32, DUR_LSB=16, PEAK_LSB=0
//   - function pack_rec()
//  Sub-module adc_evt_fifo:
//   - sync FIFO, FWFT registered output
//   - push/pop/full/empty/level; push-while-full-with-pop accepted
//  Top: FSM + ts counter + measurement regs + drop counter.
// TESTING
//  1. Threshold 100, no hyst; samples 50,150,200,180,90 valid each cycle, tready=1
//     -> one record {ts_start=t(150), dur=3, peak=200}.
//  2. Same stream with tvalid low on every other cycle -> identical dur=3, peak=200; ts_start = cycle of first 150.
//  3. cfg_min_len=4 with 3-sample event -> no record, drop_cnt stays 0; a 4-sample event -> record emitted.
//  4. tready=0, 9 events with DEPTH=8 -> level=8, drop_cnt=1; release tready -> 8 records in order, stable tdata while stalled.
//  5. HYST_EN, thr=100, hyst=20; samples 150,95,85,70
//     -> dur=3 (ends at 70), peak=150; without macro the event ends at 95 with dur=1.
//  6. cfg_enable dropped mid-event -> no record, ts=0; reset mid-drain -> tvalid=0, level=0 next cycle.

Source files
------------

// File: rtl/adc_evt_pkg.sv
// Shared state type, record layout and packing helper for the ADC event capture block.
package adc_evt_pkg;

  typedef enum logic {IDLE, ACTIVE} evt_state_t;

  localparam int REC_WIDTH = 64;
  localparam int TS_LSB    = 32;
  localparam int DUR_LSB   = 16;
  localparam int PEAK_LSB  = 0;

  // Record layout is {ts[31:0], dur[15:0], peak[15:0]}.
  function automatic logic [REC_WIDTH-1:0] pack_rec(input logic [31:0] ts,
                                                    input logic [15:0] dur,
                                                    input logic [15:0] peak);
    logic [REC_WIDTH-1:0] rec;
    rec = '0;
    rec[TS_LSB +: 32]   = ts;
    rec[DUR_LSB +: 16]  = dur;
    rec[PEAK_LSB +: 16] = peak;
    return rec;
  endfunction

endpackage

// File: rtl/adc_event_capture_if.sv
// AXI-Stream record channel from the event capture block toward the DMA side.
interface adc_event_capture_if;
  import adc_evt_pkg::*;

  logic                 tvalid;
  logic                 tready;
  logic [REC_WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);

endinterface

// File: rtl/adc_evt_fifo.sv
// Synchronous record FIFO with a registered first-word-fall-through head.
module adc_evt_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_ptr_next;
  logic [AW:0]      count;
  logic [AW:0]      count_next;
  logic             pop;
  logic             wr_en;
  logic [WIDTH-1:0] head_next;

  // A push into a full FIFO still lands when the head leaves in the same cycle.
  // The head register is reloaded from the post-edge view so it never lags a write.
  always_comb begin
    pop         = out_valid & out_ready;
    full        = (count == FULL_CNT);
    wr_en       = push & (~full | pop);
    rd_ptr_next = pop ? rd_ptr + 1'b1 : rd_ptr;
    count_next  = count + LW'(wr_en) - LW'(pop);
    if (wr_en && (wr_ptr == rd_ptr_next)) begin
      head_next = din;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      out_data  <= head_next;
    end
  end

  assign level = count;

endmodule

// File: rtl/adc_event_capture.sv
// Threshold-crossing event detector that records {start ts, duration, peak} per event.
// Define ADC_EVT_HYST_EN to release events at cfg_threshold - cfg_hysteresis instead of cfg_threshold.
module adc_event_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int TS_WIDTH   = 32,
  parameter int DUR_WIDTH  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          cfg_enable,
  input  logic [DATA_WIDTH-1:0]         cfg_threshold,
  input  logic [DATA_WIDTH-1:0]         cfg_hysteresis,
  input  logic [DUR_WIDTH-1:0]          cfg_min_len,
  adc_event_capture_if.master           m_axis,
  output logic                          sts_busy,
  output logic [$clog2(FIFO_DEPTH):0]   sts_fifo_level,
  output logic [15:0]                   sts_drop_cnt
);
  import adc_evt_pkg::*;

  evt_state_t            state;
  evt_state_t            state_next;
  logic [TS_WIDTH-1:0]   ts;
  logic [TS_WIDTH-1:0]   ts_start;
  logic [DUR_WIDTH-1:0]  dur;
  logic [DATA_WIDTH-1:0] peak;
  logic [DATA_WIDTH-1:0] off_lvl;
  logic                  start_evt;
  logic                  extend_evt;
  logic                  push;
  logic                  drop;
  logic                  fifo_full;
  logic                  fifo_valid;
  logic [REC_WIDTH-1:0]  fifo_data;
  logic [REC_WIDTH-1:0]  rec;
  logic [15:0]           drop_cnt;

`ifdef ADC_EVT_HYST_EN
  assign off_lvl = (cfg_threshold > cfg_hysteresis) ? cfg_threshold - cfg_hysteresis : '0;
`else
  logic unused_hyst;
  assign unused_hyst = ^cfg_hysteresis;
  assign off_lvl     = cfg_threshold;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn || !cfg_enable) begin
      ts <= '0;
    end else begin
      ts <= ts + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The sample that closes an event only closes it; it is never re-examined as a trigger.
  always_comb begin
    state_next = state;
    start_evt  = 1'b0;
    extend_evt = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_enable && s_axis_tvalid && (s_axis_tdata > cfg_threshold)) begin
          state_next = ACTIVE;
          start_evt  = 1'b1;
        end
      end
      ACTIVE: begin
        if (!cfg_enable) begin
          state_next = IDLE;
        end else if (s_axis_tvalid) begin
          if (s_axis_tdata > off_lvl) begin
            extend_evt = 1'b1;
          end else begin
            push       = (dur >= cfg_min_len);
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ts_start <= '0;
      dur      <= '0;
      peak     <= '0;
    end else if (start_evt) begin
      ts_start <= ts;
      dur      <= DUR_WIDTH'(1);
      peak     <= s_axis_tdata;
    end else if (extend_evt) begin
      if (dur != '1) begin
        dur <= dur + 1'b1;
      end
      if (s_axis_tdata > peak) begin
        peak <= s_axis_tdata;
      end
    end
  end

  assign rec  = pack_rec(32'(ts_start), 16'(dur), 16'(peak));
  assign drop = push & fifo_full & ~(fifo_valid & m_axis.tready);

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  adc_evt_fifo #(
    .WIDTH (REC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .push      (push),
    .din       (rec),
    .out_ready (m_axis.tready),
    .out_valid (fifo_valid),
    .out_data  (fifo_data),
    .full      (fifo_full),
    .level     (sts_fifo_level)
  );

  assign m_axis.tvalid = fifo_valid;
  assign m_axis.tdata  = fifo_data;
  assign sts_busy      = (state == ACTIVE);
  assign sts_drop_cnt  = drop_cnt;

endmodule
